// File: rtl/poly_eval_fsm.sv
// Multi-mode polynomial evaluator: operands are entered one per Go press, then a
// single shared ALU walks the Horner form one multiply or add per cycle.
module poly_eval_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Busy,
  output logic [1:0]       LoadIndex
);

  localparam logic [3:0] S_LOAD_A = 4'd0;
  localparam logic [3:0] S_A_WAIT = 4'd1;
  localparam logic [3:0] S_LOAD_B = 4'd2;
  localparam logic [3:0] S_B_WAIT = 4'd3;
  localparam logic [3:0] S_LOAD_C = 4'd4;
  localparam logic [3:0] S_C_WAIT = 4'd5;
  localparam logic [3:0] S_LOAD_X = 4'd6;
  localparam logic [3:0] S_X_WAIT = 4'd7;
  localparam logic [3:0] S_C0     = 4'd8;
  localparam logic [3:0] S_C1     = 4'd9;
  localparam logic [3:0] S_C2     = 4'd10;
  localparam logic [3:0] S_C3     = 4'd11;

  localparam logic [1:0] M_LIN  = 2'd1;
  localparam logic [1:0] M_QUAD = 2'd2;

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       load_idx_q, load_idx_d;

  logic             mode_quad_s, mode_lin_s;
  logic             alu_mul_s;
  logic [WIDTH-1:0] op_a_s, op_b_s, alu_s;

  // Mode 3 is reserved and falls through to the A*A + B path.
  assign mode_quad_s = (mode_q == M_QUAD);
  assign mode_lin_s  = (mode_q == M_LIN);

  // Shared ALU: operand routing per compute step; product and sum wrap at WIDTH.
  always_comb begin
    alu_mul_s = 1'b0;
    op_a_s    = acc_q;
    op_b_s    = b_q;
    case (state_q)
      S_C0: begin
        alu_mul_s = 1'b1;
        op_a_s    = a_q;
        op_b_s    = (mode_quad_s || mode_lin_s) ? x_q : a_q;
      end
      S_C1: begin
        alu_mul_s = 1'b0;
        op_a_s    = acc_q;
        op_b_s    = b_q;
      end
      S_C2: begin
        alu_mul_s = 1'b1;
        op_a_s    = acc_q;
        op_b_s    = x_q;
      end
      S_C3: begin
        alu_mul_s = 1'b0;
        op_a_s    = acc_q;
        op_b_s    = c_q;
      end
      default: begin
        alu_mul_s = 1'b0;
        op_a_s    = acc_q;
        op_b_s    = b_q;
      end
    endcase
    if (alu_mul_s) begin
      alu_s = op_a_s * op_b_s;
    end else begin
      alu_s = op_a_s + op_b_s;
    end
  end

  // Control FSM and datapath next-state: operand capture, Horner steps, result hold.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    mode_d   = mode_q;
    valid_d  = valid_q;
    case (state_q)
      S_LOAD_A: begin
        if (Go) begin
          a_d     = DataIn;
          mode_d  = Mode;
          valid_d = 1'b0;
          state_d = S_A_WAIT;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_A_WAIT: begin
        if (!Go) state_d = S_LOAD_B;
        else     state_d = S_A_WAIT;
      end
      S_LOAD_B: begin
        if (Go) begin
          b_d     = DataIn;
          state_d = S_B_WAIT;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_B_WAIT: begin
        if (Go)               state_d = S_B_WAIT;
        else if (mode_quad_s) state_d = S_LOAD_C;
        else if (mode_lin_s)  state_d = S_LOAD_X;
        else                  state_d = S_C0;
      end
      S_LOAD_C: begin
        if (Go) begin
          c_d     = DataIn;
          state_d = S_C_WAIT;
        end else begin
          state_d = S_LOAD_C;
        end
      end
      S_C_WAIT: begin
        if (!Go) state_d = S_LOAD_X;
        else     state_d = S_C_WAIT;
      end
      S_LOAD_X: begin
        if (Go) begin
          x_d     = DataIn;
          state_d = S_X_WAIT;
        end else begin
          state_d = S_LOAD_X;
        end
      end
      S_X_WAIT: begin
        if (!Go) state_d = S_C0;
        else     state_d = S_X_WAIT;
      end
      S_C0: begin
        acc_d   = alu_s;
        state_d = S_C1;
      end
      S_C1: begin
        acc_d = alu_s;
        if (mode_quad_s) begin
          state_d = S_C2;
        end else begin
          result_d = alu_s;
          valid_d  = 1'b1;
          state_d  = S_LOAD_A;
        end
      end
      S_C2: begin
        acc_d   = alu_s;
        state_d = S_C3;
      end
      S_C3: begin
        acc_d    = alu_s;
        result_d = alu_s;
        valid_d  = 1'b1;
        state_d  = S_LOAD_A;
      end
      default: begin
        state_d  = S_LOAD_A;
        acc_d    = {WIDTH{1'b0}};
        result_d = {WIDTH{1'b0}};
        valid_d  = 1'b0;
      end
    endcase
  end

  // Busy and LoadIndex are decoded from the next state so they can be registered.
  always_comb begin
    busy_d     = 1'b0;
    load_idx_d = 2'd0;
    case (state_d)
      S_LOAD_A, S_A_WAIT: begin busy_d = 1'b0; load_idx_d = 2'd0; end
      S_LOAD_B, S_B_WAIT: begin busy_d = 1'b0; load_idx_d = 2'd1; end
      S_LOAD_C, S_C_WAIT: begin busy_d = 1'b0; load_idx_d = 2'd2; end
      S_LOAD_X, S_X_WAIT: begin busy_d = 1'b0; load_idx_d = 2'd3; end
      S_C0, S_C1, S_C2, S_C3: begin busy_d = 1'b1; load_idx_d = 2'd0; end
      default: begin busy_d = 1'b0; load_idx_d = 2'd0; end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_LOAD_A;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      c_q        <= {WIDTH{1'b0}};
      x_q        <= {WIDTH{1'b0}};
      acc_q      <= {WIDTH{1'b0}};
      result_q   <= {WIDTH{1'b0}};
      mode_q     <= 2'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      load_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      load_idx_q <= load_idx_d;
    end
  end

  assign DataResult  = result_q;
  assign ResultValid = valid_q;
  assign Busy        = busy_q;
  assign LoadIndex   = load_idx_q;

endmodule

// File: tb/tb_poly_eval_fsm.sv
// Bench for poly_eval_fsm: 8-bit and 16-bit instances share all inputs and are
// checked against a plain-arithmetic reference of the three expressions.
module tb_poly_eval_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [1:0]  mode;
  logic [15:0] din;

  logic [7:0]  res8;
  logic        rv8, busy8;
  logic [1:0]  li8;
  logic [15:0] res16;
  logic        rv16, busy16;
  logic [1:0]  li16;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev8 = 32'd0;
  logic [31:0] prev16 = 32'd0;

  always #5 clk = ~clk;

  poly_eval_fsm #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset(rst), .Go(go), .Mode(mode), .DataIn(din[7:0]),
    .DataResult(res8), .ResultValid(rv8), .Busy(busy8), .LoadIndex(li8)
  );

  poly_eval_fsm #(.WIDTH(16)) dut16 (
    .Clock(clk), .Reset(rst), .Go(go), .Mode(mode), .DataIn(din),
    .DataResult(res16), .ResultValid(rv16), .Busy(busy16), .LoadIndex(li16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision polynomial, then reduced modulo 2^w.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [63:0] a, b, c, x,
                                        input int w);
    logic [63:0] r;
    logic [63:0] mask;
    case (m)
      2'd1:    r = a * x + b;
      2'd2:    r = a * x * x + b * x + c;
      default: r = a * a + b;
    endcase
    mask = (64'd1 << w) - 64'd1;
    return 32'(r & mask);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Enter operands for mode m; B press optionally held for hold_b extra cycles.
  task automatic load_ops(input logic [1:0] m, input logic [15:0] a, b, c, x, input int hold_b);
    logic [15:0] vals [4];
    int seq [$];
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = x;
    seq = {0, 1};
    if (m == 2'd2) seq.push_back(2);
    if (m == 2'd1 || m == 2'd2) seq.push_back(3);
    foreach (seq[k]) begin
      check("load_index8", 32'(li8), 32'(seq[k]));
      check("load_index16", 32'(li16), 32'(seq[k]));
      check("busy_in_load", 32'(busy8), 32'd0);
      if (k == 0) mode = m;
      go  = 1'b1;
      din = vals[seq[k]];
      tick(1);
      if (k == 0) begin
        check("valid_clear_on_a", 32'(rv8), 32'd0);
        check("result_kept8", 32'(res8), prev8);
        check("result_kept16", 32'(res16), prev16);
        mode = m ^ 2'b10;
      end
      if (k == 1 && hold_b > 0) begin
        for (int h = 0; h < hold_b; h++) begin
          din = 16'(h % 3 + 1);
          tick(1);
        end
        check("load_index_hold", 32'(li8), 32'd1);
      end
      go  = 1'b0;
      din = 16'($urandom);
      tick(1);
    end
  endtask

  // Wait for the result; latency counts the Go-release edge as edge 1.
  task automatic wait_result(input logic [1:0] m, input logic [15:0] a, b, c, x, input bit go_busy);
    int n = 1;
    int busy_cnt = 0;
    logic [31:0] e8, e16;
    e8  = model(m, 64'(a[7:0]), 64'(b[7:0]), 64'(c[7:0]), 64'(x[7:0]), 8);
    e16 = model(m, 64'(a), 64'(b), 64'(c), 64'(x), 16);
    check("load_index_compute", 32'(li8), 32'd0);
    while (rv8 !== 1'b1 && n < 12) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (go_busy) go = (n < 3);
      tick(1);
      n++;
    end
    go = 1'b0;
    check("latency", 32'(n), (m == 2'd2) ? 32'd5 : 32'd3);
    check("busy_cycles", 32'(busy_cnt), (m == 2'd2) ? 32'd4 : 32'd2);
    check("result8", 32'(res8), e8);
    check("result16", 32'(res16), e16);
    check("valid16", 32'(rv16), 32'd1);
    check("busy_done", 32'(busy8), 32'd0);
    check("load_index_done", 32'(li8), 32'd0);
    prev8  = e8;
    prev16 = e16;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] a, b, c, x);
    load_ops(m, a, b, c, x, 0);
    wait_result(m, a, b, c, x, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    go   = 1'b0;
    mode = 2'd0;
    din  = 16'd0;
    #12;
    check("reset_result8", 32'(res8), 32'd0);
    check("reset_result16", 32'(res16), 32'd0);
    check("reset_valid", 32'(rv8), 32'd0);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_load_index", 32'(li8), 32'd0);
    #1 rst = 1'b0;
    tick(1);

    // Mode 0 basic: 5*5+3.
    run_op(2'd0, 16'd5, 16'd3, 16'd0, 16'd0);
    check("tp_mode0", 32'(res8), 32'd28);
    tick(3);
    check("valid_holds", 32'(rv8), 32'd1);
    check("result_holds", 32'(res8), 32'd28);

    // Mode 2 with Go pulsed during compute.
    load_ops(2'd2, 16'd2, 16'd3, 16'd4, 16'd5, 0);
    wait_result(2'd2, 16'd2, 16'd3, 16'd4, 16'd5, 1'b1);
    check("tp_mode2", 32'(res8), 32'd69);
    check("go_ignored_busy", 32'(li8), 32'd0);

    // Mode 1 overflow and a 16-bit wrap case.
    run_op(2'd1, 16'd20, 16'd10, 16'd0, 16'd20);
    check("tp_mode1_wrap", 32'(res8), 32'd154);
    run_op(2'd0, 16'd300, 16'd7, 16'd0, 16'd0);
    check("tp_w16_wrap", 32'(res16), 32'd24471);

    // Go held in B wait while DataIn toggles: first capture wins.
    load_ops(2'd0, 16'd9, 16'd7, 16'd0, 16'd0, 10);
    wait_result(2'd0, 16'd9, 16'd7, 16'd0, 16'd0, 1'b0);

    // Reserved mode 3 behaves as mode 0.
    run_op(2'd3, 16'd5, 16'd3, 16'd0, 16'd0);
    check("tp_mode3", 32'(res8), 32'd28);

    for (int i = 0; i < 12; i++) begin
      run_op(2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
    end

    // Asynchronous reset while in C2 of a mode 2 operation.
    load_ops(2'd2, 16'd7, 16'd9, 16'd11, 16'd13, 0);
    tick(2);
    #1 rst = 1'b1;
    #1;
    check("abort_result8", 32'(res8), 32'd0);
    check("abort_result16", 32'(res16), 32'd0);
    check("abort_valid", 32'(rv8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_load_index", 32'(li8), 32'd0);
    #2 rst = 1'b0;
    prev8  = 32'd0;
    prev16 = 32'd0;
    tick(1);

    run_op(2'd0, 16'd4, 16'd1, 16'd0, 16'd0);
    check("tp_after_reset", 32'(res8), 32'd17);
    run_op(2'd1, 16'd6, 16'd2, 16'd0, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_eval_fsm.md
Name: poly_eval_fsm

Overview:
- Parametrised multi-mode polynomial evaluator built as a control FSM plus a datapath.
- Operands are entered one at a time on a shared DataIn bus, each entry gated by a press/release of Go.
- The block evaluates one of three selectable expressions, using a single ALU that does one multiply or one add per cycle (Horner form).
- The unsigned result is held in DataResult, and ResultValid is a level flag that stays up until the next operation starts.

Parameters:
- WIDTH, 8: width of DataIn, operand registers, accumulator and DataResult. All arithmetic is modulo 2^WIDTH.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  operand-entry strobe, level-sampled on Clock.
- Mode  in  2  expression select, sampled only when operand A is captured.
- DataIn  in  WIDTH  operand value.
- DataResult  out  WIDTH  registered result.
- ResultValid  out  1  high while DataResult holds a completed result.
- Busy  out  1  high during compute states.
- LoadIndex  out  2  operand currently expected: 0=A, 1=B, 2=C, 3=X. Reads 0 during compute.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - state = LOAD_A.
  - A, B, C, X, accumulator, mode register, DataResult all = 0.
  - ResultValid = 0, Busy = 0, LoadIndex = 0.
  - Reset mid-load or mid-compute aborts the operation; no result is produced.
- Modes, latched into mode_r at the edge where A is captured:
  - 0: A*A + B. Operands A, B.
  - 1: A*X + B. Operands A, B, X.
  - 2: A*X*X + B*X + C. Operands A, B, C, X.
  - 3: reserved, behaves exactly as mode 0.
- Load handshake, per operand k:
  - LOAD_k: when Go=1 is sampled, reg_k <= DataIn and go to LOAD_k_WAIT. Otherwise stay.
  - LOAD_k_WAIT: stay while Go=1. When Go=0 is sampled, advance to the next required operand's LOAD state or to C0.
  - Exactly one capture per press. DataIn changes while in WAIT are ignored.
  - Sequence: A, B, then C (mode 2 only), then X (modes 1, 2). Unused operands are skipped and keep their old values.
- Compute states (Busy=1), ALU result written to acc each cycle, truncated to WIDTH:
  - mode 0/3: C0 acc<=A*A; C1 acc<=acc+B (last).
  - mode 1: C0 acc<=A*X; C1 acc<=acc+B (last).
  - mode 2: C0 acc<=A*X; C1 acc<=acc+B; C2 acc<=acc*X; C3 acc<=acc+C (last).
  - Last compute edge: DataResult <= ALU output, ResultValid <= 1, state <= LOAD_A.
- Latency, counted from the edge that samples Go=0 in the final WAIT state:
  - Modes 0/1/3: ResultValid rises 3 edges later.
  - Mode 2: ResultValid rises 5 edges later.
- ResultValid and DataResult hold:
  - ResultValid stays high in LOAD_A and clears on the same edge that captures a new A.
  - DataResult keeps its old value until the next operation completes.
- Input sampling rules:
  - Go is ignored during compute states.
  - Mode is ignored everywhere except at the A capture edge.
- Unknown state encodings recover to LOAD_A with outputs at their reset values.

Test Plan:
- WIDTH=8, mode 0: A=5, B=3 -> DataResult=28; ResultValid rises 3 edges after Go release of B; LoadIndex steps 0,1 then 0.
- WIDTH=8, mode 2: A=2, B=3, C=4, X=5 -> DataResult=69 after 4 Busy cycles; LoadIndex steps 0,1,2,3.
- WIDTH=8, mode 1 overflow: A=20, B=10, X=20 -> DataResult=154 (410 mod 256).
- WIDTH=16, mode 0: A=300, B=7 -> DataResult=24471 (90007 mod 65536).
- Go held high for 10 cycles in LOAD_B_WAIT while DataIn toggles 1/2/3 -> B keeps its first captured value. Mode changed mid-operation -> ignored. Mode 3 gives the same result as mode 0.
- Reset pulsed (not aligned to Clock) during C2 of mode 2 -> all outputs 0 immediately. Following mode 0 op with A=4, B=1 -> 17. Pressing Go for the next A clears ResultValid while DataResult stays 17 until the new result.
